instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 142 ++++++++++++++
 tb/tb_instr_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I OP / OP-IMM instruction encoder with a one-deep registered output stage.
// Each accepted field set is tagged with a running address and counted.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_cls,
  input  logic [3:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [11:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  localparam logic [31:0] STEP      = ADDR_STEP[31:0];
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  OPC_IMM   = 7'b0010011;
  localparam logic [6:0]  F7_ALT    = 7'b0100000;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic        out_valid_reg;
  logic [31:0] out_instr_reg;
  logic [31:0] out_addr_reg;
  logic        out_err_reg;
  logic [31:0] addr_reg;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_shift;
  logic        enc_err;
  logic [31:0] instr_next;
  logic        accept;
  logic [1:0]  cnt_inc;
  logic [15:0] cnt_all [2];

  assign in_ready = rst_n && !clear && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    is_shift = 1'b0;
    enc_err  = 1'b0;
    case (in_aluop)
      OP_ADD:  funct3 = 3'b000;
      OP_SUB:  begin funct3 = 3'b000; funct7 = F7_ALT; end
      OP_AND:  funct3 = 3'b111;
      OP_OR:   funct3 = 3'b110;
      OP_XOR:  funct3 = 3'b100;
      OP_SLL:  begin funct3 = 3'b001; is_shift = 1'b1; end
      OP_SRL:  begin funct3 = 3'b101; is_shift = 1'b1; end
      OP_SRA:  begin funct3 = 3'b101; is_shift = 1'b1; funct7 = F7_ALT; end
      OP_SLT:  funct3 = 3'b010;
      OP_SLTU: funct3 = 3'b011;
      default: enc_err = 1'b1;
    endcase
    if (in_cls[1] || (in_cls == 2'd1 && in_aluop == OP_SUB)) begin
      enc_err = 1'b1;
    end

    if (enc_err) begin
      instr_next = NOP_INSTR;
    end else if (in_cls == 2'd0) begin
      instr_next = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_OP};
    end else if (is_shift) begin
      // Shift immediates carry only a 5-bit shamt; upper bits select SRA.
      instr_next = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_IMM};
    end else begin
      instr_next = {in_imm, in_rs1, funct3, in_rd, OPC_IMM};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= '0;
      out_addr_reg  <= BASE_ADDR;
      out_err_reg   <= 1'b0;
      addr_reg      <= BASE_ADDR;
    end else if (clear) begin
      out_valid_reg <= 1'b0;
      addr_reg      <= BASE_ADDR;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_instr_reg <= instr_next;
      out_addr_reg  <= addr_reg;
      out_err_reg   <= enc_err;
      addr_reg      <= addr_reg + STEP;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign cnt_inc = {accept && enc_err, accept};

  // Index 0 counts every acceptance, index 1 only unencodable ones.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_addr  = out_addr_reg;
  assign out_err   = out_err_reg;
  assign enc_count = cnt_all[0];
  assign err_count = cnt_all[1];

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder; expected words are hand-encoded.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cls;
  logic [3:0]  in_aluop;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cls    (in_cls),
    .in_aluop  (in_aluop),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("check %s ok: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] cls, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_valid = 1'b1;
    in_cls   = cls;
    in_aluop = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  task automatic check_word(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                            input logic err);
    check_val({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, ".instr"}, out_instr, instr);
    check_val({tag, ".addr"},  out_addr,  addr);
    check_val({tag, ".err"},   {31'd0, out_err}, {31'd0, err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_cls = '0; in_aluop = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    // Reset held for two edges
    tick();
    tick();
    check_val("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst.in_ready",  {31'd0, in_ready},  32'd0);
    check_val("rst.out_instr", out_instr, 32'd0);
    check_val("rst.out_addr",  out_addr,  32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel.in_ready",  {31'd0, in_ready}, 32'd1);
    check_val("rel.enc_count", {16'd0, enc_count}, 32'd0);
    check_val("rel.err_count", {16'd0, err_count}, 32'd0);

    // Back-to-back stream of legal encodings
    set_req(2'd0, 4'd0, 5'd1, 5'd2, 5'd3, 12'h000);   // ADD
    tick();
    check_word("add", 32'h003100B3, 32'h0, 1'b0);
    set_req(2'd0, 4'd1, 5'd5, 5'd6, 5'd7, 12'h000);   // SUB
    tick();
    check_word("sub", 32'h407302B3, 32'h4, 1'b0);
    set_req(2'd1, 4'd7, 5'd1, 5'd1, 5'd0, 12'hFE3);   // SRAI
    tick();
    check_word("srai", 32'h4030D093, 32'h8, 1'b0);
    set_req(2'd1, 4'd0, 5'd1, 5'd0, 5'd0, 12'hFFF);   // ADDI
    tick();
    check_word("addi", 32'hFFF00093, 32'hC, 1'b0);
    set_req(2'd1, 4'd5, 5'd2, 5'd3, 5'd0, 12'hFE5);   // SLLI, imm[11:5] ignored
    tick();
    check_word("slli", 32'h00519113, 32'h10, 1'b0);
    set_req(2'd0, 4'd9, 5'd4, 5'd5, 5'd6, 12'h000);   // SLTU
    tick();
    check_word("sltu", 32'h0062B233, 32'h14, 1'b0);
    check_val("stream.enc_count", {16'd0, enc_count}, 32'd6);
    check_val("stream.err_count", {16'd0, err_count}, 32'd0);

    // Clear while a word is held and a request is pending
    set_req(2'd0, 4'd2, 5'd1, 5'd1, 5'd1, 12'h000);
    clear = 1'b1;
    #1;
    check_val("clr.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0;
    check_val("clr.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("clr.enc_count", {16'd0, enc_count}, 32'd0);
    check_val("clr.err_count", {16'd0, err_count}, 32'd0);

    // Unencodable requests still accepted, emitted as NOP with err
    set_req(2'd1, 4'd1, 5'd1, 5'd2, 5'd0, 12'h123);   // I-type SUB
    tick();
    check_word("isub", 32'h00000013, 32'h0, 1'b1);
    set_req(2'd0, 4'd12, 5'd1, 5'd2, 5'd3, 12'h000);  // reserved op
    tick();
    check_word("op12", 32'h00000013, 32'h4, 1'b1);
    check_val("err.enc_count", {16'd0, enc_count}, 32'd2);
    check_val("err.err_count", {16'd0, err_count}, 32'd2);
    set_req(2'd2, 4'd0, 5'd1, 5'd2, 5'd3, 12'h000);   // reserved class
    tick();
    check_word("cls2", 32'h00000013, 32'h8, 1'b1);
    check_val("cls2.err_count", {16'd0, err_count}, 32'd3);
    in_valid = 1'b0;
    tick();
    check_val("drain.out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A held for three cycles while B waits
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_req(2'd0, 4'd0, 5'd1, 5'd2, 5'd3, 12'h000);   // A = ADD
    tick();
    check_word("bpA", 32'h003100B3, 32'h0, 1'b0);
    set_req(2'd0, 4'd1, 5'd5, 5'd6, 5'd7, 12'h000);   // B = SUB
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("bp%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      tick();
      check_word($sformatf("bp%0d.hold", i), 32'h003100B3, 32'h0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp.rel.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_word("bpB", 32'h407302B3, 32'h4, 1'b0);
    in_valid = 1'b0;
    tick();
    check_val("bp.done.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("bp.enc_count", {16'd0, enc_count}, 32'd2);

    // Reset discards a held word and overrides a pending request
    set_req(2'd0, 4'd3, 5'd1, 5'd2, 5'd3, 12'h000);   // OR
    tick();
    check_word("or", 32'h003160B3, 32'h8, 1'b0);
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check_val("rst2.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst2.enc_count", {16'd0, enc_count}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_req(2'd0, 4'd4, 5'd1, 5'd2, 5'd3, 12'h000);   // XOR
    tick();
    check_word("xor", 32'h003140B3, 32'h0, 1'b0);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
